// File: rtl/risc_vector_pkg.sv
// Shared definitions for the risc_vector memory side: FSM state encoding and
// default memory geometry.
package risc_vector_pkg;

   localparam int DEF_MEM_ADDR_WIDTH = 5;
   localparam int DEF_MEM_DATA_WIDTH = 16;
   localparam int DEF_MEM_NUMBER     = 32;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_READ = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_SEND = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE = S_IDLE,
      ST_READ = S_READ,
      ST_WAIT = S_WAIT,
      ST_SEND = S_SEND,
      ST_FIN  = S_FIN
   } dump_state_t;

endpackage

// File: rtl/mem_dump_unit.sv
// Streams a wrapping address range of a synchronous memory out over valid/ready,
// one read per word (3 cycles/word when unstalled); SEND holds the word until accepted.
module mem_dump_unit
   import risc_vector_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
   parameter int MEM_DATA_WIDTH = DEF_MEM_DATA_WIDTH,
   parameter int MEM_NUMBER     = DEF_MEM_NUMBER
) (
   input  logic                      Clk_i,
   input  logic                      Rst_i,
   input  logic                      Start_i,
   input  logic [MEM_ADDR_WIDTH-1:0] Base_i,
   input  logic [MEM_ADDR_WIDTH:0]   Len_i,
   output logic                      Busy_o,
   output logic                      Done_o,
   output logic                      Mem_rd_en_o,
   output logic [MEM_ADDR_WIDTH-1:0] Mem_addr_o,
   input  logic [MEM_DATA_WIDTH-1:0] Mem_rdata_i,
   output logic                      Dump_valid_o,
   output logic [MEM_DATA_WIDTH-1:0] Dump_data_o,
   output logic [MEM_ADDR_WIDTH-1:0] Dump_addr_o,
   output logic                      Dump_last_o,
   input  logic                      Dump_ready_i
);

   localparam logic [MEM_ADDR_WIDTH:0]   LEN_MAX   = (MEM_ADDR_WIDTH+1)'(MEM_NUMBER);
   localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_LAST = MEM_ADDR_WIDTH'(MEM_NUMBER - 1);
   localparam logic [MEM_ADDR_WIDTH:0]   ONE_LEFT  = (MEM_ADDR_WIDTH+1)'(1);

   dump_state_t               state;
   logic [MEM_ADDR_WIDTH-1:0] addr_cnt;
   logic [MEM_ADDR_WIDTH:0]   remaining;
   logic [MEM_ADDR_WIDTH-1:0] addr_next;
   logic [MEM_ADDR_WIDTH:0]   len_sat;

   assign addr_next = (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + 1'b1;
   assign len_sat   = (Len_i > LEN_MAX) ? LEN_MAX : Len_i;

   // Outputs are registered alongside the state so each one lines up with the state it belongs to.
   always_ff @(posedge Clk_i or posedge Rst_i) begin
      if (Rst_i) begin
         state        <= ST_IDLE;
         addr_cnt     <= '0;
         remaining    <= '0;
         Busy_o       <= 1'b0;
         Done_o       <= 1'b0;
         Mem_rd_en_o  <= 1'b0;
         Mem_addr_o   <= '0;
         Dump_valid_o <= 1'b0;
         Dump_data_o  <= '0;
         Dump_addr_o  <= '0;
         Dump_last_o  <= 1'b0;
      end else begin
         Done_o      <= 1'b0;
         Mem_rd_en_o <= 1'b0;
         Mem_addr_o  <= '0;
         case (state)
            ST_IDLE: begin
               if (Start_i) begin
                  Busy_o <= 1'b1;
                  if (Len_i == '0) begin
                     state  <= ST_FIN;
                     Done_o <= 1'b1;
                  end else begin
                     addr_cnt    <= Base_i;
                     remaining   <= len_sat;
                     state       <= ST_READ;
                     Mem_rd_en_o <= 1'b1;
                     Mem_addr_o  <= Base_i;
                  end
               end
            end
            ST_READ: state <= ST_WAIT;
            ST_WAIT: begin
               Dump_valid_o <= 1'b1;
               Dump_data_o  <= Mem_rdata_i;
               Dump_addr_o  <= addr_cnt;
               Dump_last_o  <= (remaining == ONE_LEFT);
               state        <= ST_SEND;
            end
            ST_SEND: begin
               if (Dump_ready_i) begin
                  Dump_valid_o <= 1'b0;
                  Dump_data_o  <= '0;
                  Dump_addr_o  <= '0;
                  Dump_last_o  <= 1'b0;
                  addr_cnt     <= addr_next;
                  remaining    <= remaining - 1'b1;
                  if (remaining == ONE_LEFT) begin
                     state  <= ST_FIN;
                     Done_o <= 1'b1;
                  end else begin
                     state       <= ST_READ;
                     Mem_rd_en_o <= 1'b1;
                     Mem_addr_o  <= addr_next;
                  end
               end
            end
            ST_FIN: begin
               state  <= ST_IDLE;
               Busy_o <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               Busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
